// File: rtl/shifter_pkg.sv
// Shared types and constants for the 8-bit logical left barrel shifter.
package shifter_pkg;
  localparam int WIDTH      = 8;
  localparam int SHAMT_BITS = 3;

  typedef logic [7:0] byte_t;
endpackage

// File: rtl/shift_stage.sv
// One mux level of the log shifter: pass through or shift left by a fixed amount.
module shift_stage
  import shifter_pkg::*;
#(
  parameter int AMT = 1
) (
  input  byte_t in,
  input  logic  sel,
  output byte_t out
);

  assign out = sel ? byte_t'(in << AMT) : in;

endmodule

// File: rtl/q10_shifter.sv
// 8-bit logical left barrel shifter: three fixed-shift mux stages, zero forcing
// for counts of 8 or more, and a single output register.
module q10_shifter
  import shifter_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  byte_t d,
  input  byte_t n,
  output byte_t w
);

  byte_t w_s0;
  byte_t w_s1;
  byte_t w_s2;
  byte_t w_core;
  logic  w_sat;
  byte_t r_w;

  shift_stage #(.AMT(1)) u_stage0 (.in(d),    .sel(n[0]), .out(w_s0));
  shift_stage #(.AMT(2)) u_stage1 (.in(w_s0), .sel(n[1]), .out(w_s1));
  shift_stage #(.AMT(4)) u_stage2 (.in(w_s1), .sel(n[2]), .out(w_s2));

  // Any count bit above the 3-bit shift amount pushes every data bit out.
  assign w_sat  = |n[WIDTH-1:SHAMT_BITS];
  assign w_core = w_sat ? '0 : w_s2;

  // Output register stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_w <= '0;
    end else begin
      r_w <= w_core;
    end
  end

  assign w = r_w;

endmodule

// File: tb/tb_q10_shifter.sv
// Self-checking bench for q10_shifter against an arithmetic reference model.
module tb_q10_shifter;

  logic       clk;
  logic       rst;
  logic [7:0] d;
  logic [7:0] n;
  logic [7:0] w;

  int pass_cnt;
  int total_cnt;

  q10_shifter dut (
    .clk(clk),
    .rst(rst),
    .d  (d),
    .n  (n),
    .w  (w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // Reference: multiply by 2**n and keep the low byte; counts >= 8 lose everything.
  function automatic logic [7:0] ref_shift(input logic [7:0] dd, input logic [7:0] nn);
    longint v;
    if (nn >= 8) return 8'h00;
    v = longint'(dd) * (longint'(1) << nn);
    return 8'(v % 256);
  endfunction

  // Drive one input pair, let it be captured, and settle just after the edge.
  task automatic drive_and_clock(input logic [7:0] dd, input logic [7:0] nn);
    @(negedge clk);
    d = dd;
    n = nn;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    #2;
    d   = 8'hFF;
    n   = 8'h00;
    rst = 1'b1;
    #1;
    total_cnt++;
    if (w !== 8'h00) $display("FAIL reset_async: w=%h expected=%h", w, 8'h00);
    else pass_cnt++;
    @(posedge clk);
    #1;
    total_cnt++;
    if (w !== 8'h00) $display("FAIL reset_hold: w=%h expected=%h", w, 8'h00);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    total_cnt++;
    if (w !== 8'hFF) $display("FAIL reset_release: w=%h expected=%h", w, 8'hFF);
    else pass_cnt++;
  endtask

  task automatic test_directed(input string name, input logic [7:0] dd,
                               input logic [7:0] nn, input logic [7:0] exp);
    drive_and_clock(dd, nn);
    total_cnt++;
    if (w !== exp) $display("FAIL %s: d=%h n=%h w=%h expected=%h", name, dd, nn, w, exp);
    else pass_cnt++;
  endtask

  task automatic test_saturation;
    test_directed("sat_n80", 8'hFF, 8'h80, 8'h00);
    test_directed("sat_n10", 8'hFF, 8'h10, 8'h00);
    test_directed("sat_n20", 8'hFF, 8'h20, 8'h00);
    test_directed("sat_n08", 8'hFF, 8'h08, 8'h00);
  endtask

  task automatic test_zero;
    test_directed("zero_n00", 8'h00, 8'h00, 8'h00);
    test_directed("zero_n20", 8'h00, 8'h20, 8'h00);
  endtask

  task automatic test_inrange;
    test_directed("shift_ff_1", 8'hFF, 8'h01, 8'hFE);
    test_directed("shift_58_3", 8'h58, 8'h03, 8'hC0);
    test_directed("shift_ff_7", 8'hFF, 8'h07, 8'h80);
    test_directed("shift_58_0", 8'h58, 8'h00, 8'h58);
    for (int k = 0; k < 8; k++) begin
      test_directed("shift_sweep", 8'hA5, 8'(k), ref_shift(8'hA5, 8'(k)));
    end
  endtask

  // New inputs every cycle, applied right after each edge; w must update only
  // at the following edge and must then match exactly the pair it captured.
  task automatic test_back_to_back;
    logic [7:0] dq [$];
    logic [7:0] nq [$];
    logic [7:0] exp_prev;
    logic [7:0] exp_cur;
    dq = '{8'hFF, 8'h58, 8'hFF, 8'h58, 8'hFF, 8'hFF, 8'h00};
    nq = '{8'h01, 8'h03, 8'h07, 8'h00, 8'h80, 8'h10, 8'h20};
    for (int k = 0; k < 40; k++) begin
      dq.push_back(8'($urandom_range(0, 255)));
      nq.push_back((k % 3 == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 9)));
    end
    @(posedge clk);
    #1;
    exp_prev = w;
    foreach (dq[k]) begin
      d = dq[k];
      n = nq[k];
      exp_cur = ref_shift(dq[k], nq[k]);
      @(negedge clk);
      total_cnt++;
      if (w !== exp_prev) $display("FAIL b2b_hold[%0d]: w=%h expected=%h", k, w, exp_prev);
      else pass_cnt++;
      @(posedge clk);
      #1;
      total_cnt++;
      if (w !== exp_cur)
        $display("FAIL b2b_result[%0d]: d=%h n=%h w=%h expected=%h", k, dq[k], nq[k], w, exp_cur);
      else pass_cnt++;
      exp_prev = exp_cur;
    end
  endtask

  task automatic test_async_reset_midstream;
    drive_and_clock(8'hFF, 8'h01);
    total_cnt++;
    if (w !== 8'hFE) $display("FAIL mid_pre: w=%h expected=%h", w, 8'hFE);
    else pass_cnt++;
    d = 8'h58;
    n = 8'h03;
    #2;
    rst = 1'b1;
    #1;
    total_cnt++;
    if (w !== 8'h00) $display("FAIL mid_async: w=%h expected=%h", w, 8'h00);
    else pass_cnt++;
    @(posedge clk);
    #1;
    total_cnt++;
    if (w !== 8'h00) $display("FAIL mid_hold: w=%h expected=%h", w, 8'h00);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    d = 8'h0F;
    n = 8'h02;
    @(posedge clk);
    #1;
    total_cnt++;
    if (w !== 8'h3C) $display("FAIL mid_release: w=%h expected=%h", w, 8'h3C);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst = 1'b0;
    d   = 8'h00;
    n   = 8'h00;
    repeat (2) @(posedge clk);
    test_reset();
    test_saturation();
    test_zero();
    test_inrange();
    test_back_to_back();
    test_async_reset_midstream();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
